event_pulse_throttler: RTL and testbench
========================================

EVENT_PULSE_THROTTLER -- requirements
Module: event_pulse_throttler

Interface
REQ-001 SHALL have parameter MIN_GAP, default 4, the number of low cycles forced between consecutive output pulses (legal range 1..255).
REQ-002 SHALL have parameter PENDING_WIDTH, default 4, the width of the pending-event counter (legal range 2..8).
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port event_i  input  1  a single-cycle event request; may be asserted on consecutive cycles.
REQ-006 SHALL have port pulse_o  output  1  a registered single-cycle pulse that feeds the source side of the pulse synchronizer.
REQ-007 SHALL have port pending_o  output  PENDING_WIDTH  the number of accepted events not yet emitted.
REQ-008 SHALL have port busy_o  output  1  high when state != IDLE or pending_o != 0.
REQ-009 SHALL have port ovf_clear_i  input  1  clears the sticky overflow flag (present only with EVT_OVERFLOW_FLAG_EN).
REQ-010 SHALL have port overflow_o  output  1  sticky flag marking a dropped event (present only with EVT_OVERFLOW_FLAG_EN).

Function
REQ-011 SHALL implement the FSM states IDLE, PULSE and GAP.
REQ-012 SHALL take the transition IDLE->PULSE when pending_o != 0; otherwise it SHALL stay in IDLE.
REQ-013 SHALL take the transition PULSE->GAP unconditionally after 1 cycle, loading the gap counter with MIN_GAP.
REQ-014 SHALL decrement the gap counter once per cycle in GAP.
REQ-015 SHALL leave GAP on the cycle its gap counter reaches 1: to PULSE if pending_o != 0, else to IDLE.
REQ-016 SHALL drive pulse_o = 1 exactly in state PULSE; output pulse rising edges SHALL therefore be at least MIN_GAP+1 cycles apart.
REQ-017 SHALL decrement pending_o on every transition into PULSE.
REQ-018 SHALL increment pending_o in the cycle after event_i is sampled high.
REQ-019 SHALL leave pending_o unchanged on a simultaneous increment and decrement, including when pending_o is at its maximum.
REQ-020 SHALL give a latency of 2 cycles from event_i high in cycle N to pulse_o high in cycle N+2, when idle.
REQ-021 SHALL saturate pending_o at 2^PENDING_WIDTH-1; an increment without a decrement while saturated SHALL drop the event.
REQ-022 SHALL never drop an event while pending_o is below its maximum, and SHALL never emit a pulse that was not preceded by an accepted event.

Reset
REQ-023 SHALL, in the cycle after rst_i is sampled high: state=IDLE, pending_o=0, gap counter=0, pulse_o=0, busy_o=0, overflow_o=0.
REQ-024 SHALL abandon all pending events when reset is asserted mid-operation, in any state, with no pulse emitted afterwards.
REQ-025 SHALL give rst_i priority over event_i and ovf_clear_i.

Configuration
REQ-026 SHALL, with EVT_OVERFLOW_FLAG_EN defined, include ovf_clear_i and overflow_o.
REQ-027 SHALL set overflow_o on a dropped event and clear it on ovf_clear_i; set SHALL win over a simultaneous clear.
REQ-028 SHALL, without EVT_OVERFLOW_FLAG_EN, omit both overflow ports and drop saturated events silently, with all other behaviour identical.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, PULSE, GAP) and the gap-counter width constant (8 bits) in the shared cdc_pkg package.
REQ-030 SHALL implement the saturating up/down pending counter as sub-module sat_updown_counter (parameter WIDTH; ports inc, dec, count, saturated).

Verification (MIN_GAP=4, PENDING_WIDTH=4)
REQ-031 SHALL verify a single event: event_i high in cycle 10 -> pulse_o high in cycle 12 only; busy_o low from cycle 17.
REQ-032 SHALL verify a burst of 3: event_i high in cycles 10..12 -> pulse_o high in cycles 12, 17 and 22, and nowhere else.
REQ-033 SHALL verify saturation: event_i high in cycles 10..33 (24 events) -> pending_o peaks at 15, exactly 20 pulses total, overflow_o=1.
REQ-034 SHALL verify simultaneous increment/decrement: event_i high on a PULSE-entry cycle with pending_o=3 -> pending_o stays 3.
REQ-035 SHALL verify reset mid-operation: rst_i high for 1 cycle during GAP with pending_o=5 -> next cycle pending_o=0, busy_o=0, and no pulse for 50 cycles.
REQ-036 SHALL verify clear/set collision: ovf_clear_i high in the same cycle as a dropped event -> overflow_o stays 1; a later lone clear -> overflow_o=0 the next cycle.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and constants for the pulse-synchronizer source side.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cdc_pkg;

  // Width of the inter-pulse gap counter; MIN_GAP must fit in it (1..255).
  localparam int GAP_CNT_W = 8;

  // Throttler FSM: wait for work, emit one pulse, then hold the line low.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } thr_state_t;

  // Value loaded into the gap counter when leaving PULSE.
  function automatic logic [GAP_CNT_W-1:0] gap_load(input int unsigned min_gap);
    return GAP_CNT_W'(min_gap);
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter holding the number of accepted, not yet emitted events.
// Latency: count reflects inc/dec one clock after they are sampled.
// Backpressure: none; an increment while saturated (and no decrement) is discarded.
module sat_updown_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             saturated
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  assign saturated = (count == CNT_MAX);

  // Count register: a simultaneous inc and dec cancel, even at the ceiling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (!saturated) begin
        count <= count + 1'b1;
      end
    end else if (dec && !inc) begin
      // Never wrap below zero if a decrement ever arrives on an empty count.
      if (count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_pulse_throttler.sv
// Turns single-cycle event requests into registered pulses spaced at least MIN_GAP+1 cycles apart.
// Latency: event_i in cycle N gives pulse_o in cycle N+2 when idle.
// Backpressure: none; events queue in a saturating counter, excess events are dropped (flagged with EVT_OVERFLOW_FLAG_EN).
module event_pulse_throttler
  import cdc_pkg::*;
#(
  parameter int unsigned MIN_GAP       = 4,
  parameter int unsigned PENDING_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     event_i,
`ifdef EVT_OVERFLOW_FLAG_EN
  input  logic                     ovf_clear_i,
  output logic                     overflow_o,
`endif
  output logic                     pulse_o,
  output logic [PENDING_WIDTH-1:0] pending_o,
  output logic                     busy_o
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = gap_load(MIN_GAP);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(1);

  thr_state_t           state_q;
  thr_state_t           state_d;
  logic [GAP_CNT_W-1:0] gap_q;
  logic [GAP_CNT_W-1:0] gap_d;
  logic                 pulse_q;
  logic                 enter_pulse;
  logic                 pending_nz;
  logic                 pend_saturated;
  logic                 drop;

  // Pending-event queue depth; every entry into PULSE consumes one event.
  sat_updown_counter #(
    .WIDTH (PENDING_WIDTH)
  ) u_pending (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc       (event_i),
    .dec       (enter_pulse),
    .count     (pending_o),
    .saturated (pend_saturated)
  );

  assign pending_nz = |pending_o;

  // An event is lost only when the queue is full and nothing leaves this cycle.
  assign drop = event_i && !enter_pulse && pend_saturated;

  // Next-state logic: launch a pulse whenever work is queued and spacing allows.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    enter_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_nz) begin
          state_d     = PULSE;
          enter_pulse = 1'b1;
        end
      end
      PULSE: begin
        state_d = GAP;
        gap_d   = GAP_LOAD;
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        // Leaving on 1 gives exactly MIN_GAP low cycles; <= also recovers from 0.
        if (gap_q <= GAP_LAST) begin
          if (pending_nz) begin
            state_d     = PULSE;
            enter_pulse = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // State, gap counter and the registered pulse output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gap_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pulse_q <= enter_pulse;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = (state_q != IDLE) || pending_nz;

`ifdef EVT_OVERFLOW_FLAG_EN
  logic ovf_q;

  // Sticky overflow flag: a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clear_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow_o = ovf_q;
`else
  // Without the flag, a dropped event simply disappears.
  logic drop_unused;
  assign drop_unused = drop;
`endif

endmodule

// File: tb/tb_event_pulse_throttler.sv
module tb_event_pulse_throttler;

  localparam int MIN_GAP = 4;
  localparam int PW      = 4;
  localparam int PMAX    = 15;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          event_i;
  logic          ovf_clear_i;
  logic          pulse_o;
  logic          busy_o;
  logic [PW-1:0] pending_o;
`ifdef EVT_OVERFLOW_FLAG_EN
  logic          overflow_o;
`endif

  always #5 clk_i = ~clk_i;

  event_pulse_throttler #(
    .MIN_GAP       (MIN_GAP),
    .PENDING_WIDTH (PW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .event_i     (event_i),
`ifdef EVT_OVERFLOW_FLAG_EN
    .ovf_clear_i (ovf_clear_i),
    .overflow_o  (overflow_o),
`endif
    .pulse_o     (pulse_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int lc    = 0;

  // Reference model: queue depth plus time of the last pulse.
  int m_pend  = 0;
  int m_last  = -1000;
  bit m_pulse = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_valid = 1'b0;

  logic hist_pulse [256];
  int   hist_pend  [256];
  logic hist_busy  [256];
  logic hist_ovf   [256];

  logic          obs_pulse;
  logic          obs_busy;
  logic [PW-1:0] obs_pend;

  typedef struct {
    logic ev;
    logic rst;
    logic chk;
    logic pulse;
    int   pend;
    logic busy;
  } vec_t;

  vec_t tbl [60];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model rules: a pulse fires as soon as an event is queued and the last
  // pulse is at least MIN_GAP+1 cycles back; events enter the queue one cycle
  // after they are seen and are lost only when the queue is full.
  task automatic advance(input logic ev, input logic clr, input logic rst);
    bit nxt;
    bit dropped;
    if (rst) begin
      m_pend  = 0;
      m_last  = -1000;
      m_pulse = 1'b0;
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      nxt     = (m_pend > 0) && ((cyc + 1 - m_last) >= MIN_GAP + 1);
      dropped = 1'b0;
      if (ev && !nxt) begin
        if (m_pend == PMAX) dropped = 1'b1;
        else m_pend++;
      end else if (!ev && nxt) begin
        m_pend--;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_pulse = nxt;
      if (nxt) m_last = cyc + 1;
    end
    cyc++;
    lc++;
  endtask

  task automatic step(input logic ev, input logic clr, input logic rst);
    event_i     = ev;
    ovf_clear_i = clr;
    rst_i       = rst;
    @(negedge clk_i);
    obs_pulse = pulse_o;
    obs_busy  = busy_o;
    obs_pend  = pending_o;
    if (lc < 256) begin
      hist_pulse[lc] = pulse_o;
      hist_pend[lc]  = int'(pending_o);
      hist_busy[lc]  = busy_o;
`ifdef EVT_OVERFLOW_FLAG_EN
      hist_ovf[lc]   = overflow_o;
`else
      hist_ovf[lc]   = 1'b0;
`endif
    end
    if (m_valid) begin
      check("model_pulse", 32'(pulse_o), 32'(m_pulse));
      check("model_pending", 32'(pending_o), m_pend);
      check("model_busy", 32'(busy_o),
            32'((m_pend > 0) || ((cyc - m_last) <= MIN_GAP)));
`ifdef EVT_OVERFLOW_FLAG_EN
      check("model_overflow", 32'(overflow_o), 32'(m_ovf));
`endif
    end
    @(posedge clk_i);
    #1;
    advance(ev, clr, rst);
  endtask

  task automatic start_scenario();
    lc = 0;
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int peak;
    int npulse;
    int density;

    rst_i       = 1'b1;
    event_i     = 1'b0;
    ovf_clear_i = 1'b0;

    // Table: rows 0..29 single event at 10, rows 30..59 burst at 10..12.
    for (int i = 0; i < 60; i++) begin
      tbl[i] = '{ev: 1'b0, rst: (i % 30 == 0), chk: (i % 30 != 0),
                 pulse: 1'b0, pend: 0, busy: 1'b0};
    end
    tbl[10].ev = 1'b1;
    tbl[11].pend = 1;
    for (int i = 11; i <= 16; i++) tbl[i].busy = 1'b1;
    tbl[12].pulse = 1'b1;
    for (int i = 40; i <= 42; i++) tbl[i].ev = 1'b1;
    tbl[41].pend = 1;
    tbl[42].pend = 1;
    for (int i = 43; i <= 46; i++) tbl[i].pend = 2;
    for (int i = 47; i <= 51; i++) tbl[i].pend = 1;
    tbl[42].pulse = 1'b1;
    tbl[47].pulse = 1'b1;
    tbl[52].pulse = 1'b1;
    for (int i = 41; i <= 56; i++) tbl[i].busy = 1'b1;

    @(posedge clk_i);
    #1;

    for (int i = 0; i < 60; i++) begin
      if (tbl[i].rst) lc = 0;
      step(tbl[i].ev, 1'b0, tbl[i].rst);
      if (tbl[i].chk) begin
        check($sformatf("tbl_pulse[%0d]", i), 32'(obs_pulse), 32'(tbl[i].pulse));
        check($sformatf("tbl_pending[%0d]", i), 32'(obs_pend), tbl[i].pend);
        check($sformatf("tbl_busy[%0d]", i), 32'(obs_busy), 32'(tbl[i].busy));
      end
    end

    // Saturation with a clear colliding with a drop, then a lone clear.
    start_scenario();
    for (int c = 1; c < 140; c++) begin
      step((c >= 10 && c <= 33), (c == 30 || c == 50), 1'b0);
    end
    peak   = 0;
    npulse = 0;
    for (int c = 1; c < 140; c++) begin
      if (hist_pend[c] > peak) peak = hist_pend[c];
      if (hist_pulse[c] === 1'b1) npulse++;
    end
    check("sat_peak_pending", peak, 15);
    check("sat_pulse_count", npulse, 20);
`ifdef EVT_OVERFLOW_FLAG_EN
    check("sat_overflow_set", 32'(hist_ovf[40]), 1);
    check("ovf_set_wins_clear", 32'(hist_ovf[31]), 1);
    check("ovf_before_lone_clear", 32'(hist_ovf[50]), 1);
    check("ovf_lone_clear", 32'(hist_ovf[51]), 0);
`endif

    // Event on a PULSE-entry cycle while three events are queued.
    start_scenario();
    for (int c = 1; c <= 40; c++) begin
      step((c >= 10 && c <= 13) || c == 16, 1'b0, 1'b0);
    end
    check("simul_pending_before", hist_pend[16], 3);
    check("simul_pulse", 32'(hist_pulse[17]), 1);
    check("simul_pending_after", hist_pend[17], 3);

    // Reset during GAP with five events queued.
    start_scenario();
    for (int c = 1; c <= 70; c++) begin
      step((c >= 10 && c <= 15), 1'b0, (c == 16));
    end
    check("rst_first_pulse", 32'(hist_pulse[12]), 1);
    check("rst_pending_before", hist_pend[16], 5);
    check("rst_pending_after", hist_pend[17], 0);
    check("rst_busy_after", 32'(hist_busy[17]), 0);
    npulse = 0;
    for (int c = 17; c <= 66; c++) begin
      if (hist_pulse[c] !== 1'b0) npulse++;
    end
    check("rst_no_pulse_50", npulse, 0);

    // Randomized traffic with varying event density, clears and resets.
    start_scenario();
    for (int c = 1; c < 3000; c++) begin
      case ((c / 500) % 4)
        0: density = 10;
        1: density = 35;
        2: density = 95;
        default: density = 60;
      endcase
      step(($urandom_range(0, 99) < density),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
